serial_bus_slave: RTL and testbench
===================================

# serial_bus_slave

Serial bus responder that decodes frames from the bus master. Frames use three lines: a `valid_s` start strobe, an MSB-first `addr_tx` stream, and an MSB-first `data_tx` stream. The block writes and reads a local byte memory in single or burst mode. It returns read data on one serial line, framed by `slave_valid`, and paces burst writes with `slave_ready`. One instance sits on the shared bus per slave ID.

## Interface
- `SLAVE_ID`, default 2'd0: matched against frame address bits [13:12].
- `MEM_DEPTH`, default 4096: local byte memory depth, addressed by frame address bits [11:0].
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset. Clears all state and outputs; memory contents are not cleared.
- `valid_s`  in  1  frame or beat start strobe from the master.
- `write_en_slave`  in  1  1 = write, 0 = read; sampled in the `valid_s` cycle.
- `addr_tx`  in  1  serial address, MSB first.
- `data_tx`  in  1  serial write data, MSB first.
- `burst_mode`  in  1  serial 3-bit burst code, MSB first.
- `data_rx`  out  1  serial read data to the master, MSB first.
- `slave_ready`  out  1  slave idle and able to accept a frame or burst beat.
- `slave_valid`  out  1  one-cycle strobe; the read byte starts on the next cycle.
- `rd_data`  out  8  last byte read (debug).
- `state`  out  4  current FSM state (debug).

## Operation
- States:
  - `IDLE` (ready=1): `valid_s`=1 → `ADDR`. Latch `write_en_slave`, clear bit_cnt, beat_cnt and shift registers.
  - `ADDR`: 14 cycles. Shift `addr_tx` into a 14-bit register.
    - Bit cycles 7–14: also shift `data_tx` into an 8-bit register.
    - Bit cycles 12–14: also shift `burst_mode` into the 3-bit code.
    - After bit 14, go to `COMMIT`.
  - `COMMIT`, one cycle:
    - ID mismatch → `IDLE`, no memory access, no strobes.
    - Write → store the byte at addr[11:0]. If code==0, go to `IDLE`; else go to `BW_WAIT`.
    - Read → `RD_FETCH`.
  - `RD_FETCH`: latch mem[ptr] into the output shift register and `rd_data` → `RD_VALID`.
  - `RD_VALID`: `slave_valid`=1 for one cycle → `RD_SHIFT`.
  - `RD_SHIFT`: 8 cycles, driving the bits on `data_rx` MSB first. Then:
    - beat_cnt+1 == size, or code==0 → `IDLE`.
    - Otherwise increment ptr and beat_cnt → `RD_FETCH`.
  - `BW_WAIT` (ready=1): `valid_s`=1 → `BW_DATA`, clear bit_cnt.
  - `BW_DATA`: 8 cycles shifting `data_tx`. Then store the byte at ptr+1, increment ptr and beat_cnt. If beat_cnt reaches size-1 → `IDLE`; else → `BW_WAIT`.
- Burst size from code c: 0 → 1 beat; 1..7 → 8,16,32,64,128,256,512 beats (8<<(c-1)). beat_cnt is 10 bits.
- The frame byte counts as beat 0.
- The 12-bit local pointer wraps 4095→0 within a burst. The ID bits never change during a burst.
- Write data in the frame is ignored for reads.

## Timing
- Reset values: `data_rx`=0, `slave_valid`=0, `slave_ready`=1, `rd_data`=0, `state`=`IDLE`.
- Frame timing: `valid_s` sampled at edge 0; address bit k sampled at edge k (k=1..14); commit at edge 15.
- Single-read latency: `slave_valid` high in cycle 17 after `valid_s`. Bit 7 on `data_rx` in cycle 18, bit 0 in cycle 25. `data_rx` returns to 0 afterwards.
- Burst-read beats are back-to-back: an 11-cycle period (fetch, valid, 8 bits, plus the 1-cycle decision).
- `valid_s` outside `IDLE`/`BW_WAIT` is ignored; no reframing mid-frame.
- `valid_s` in the same cycle as the `IDLE` re-entry edge is not seen; the frame starts only from `IDLE`.
- `slave_ready` is registered. It drops the cycle after the accepting `valid_s`.
- Reset mid-frame or mid-burst aborts the transfer: no partial byte is written, and `IDLE` is reached immediately.

## Test plan
- Write 0xA5 to address 0x0123 (ID 0, code 0), then read it back → `slave_valid` at cycle 17; `data_rx` bits 1,0,1,0,0,1,0,1 on cycles 18–25; `rd_data`=0xA5.
- Write to address 0x1123 with `SLAVE_ID`=0 → memory unchanged, `slave_valid` never asserts, `slave_ready` back to 1 at cycle 16.
- Burst write, code 1, start address 0x0FFE, data 0x10 then 8 beats total of 0x10..0x17 → mem[0xFFE]=0x10, mem[0xFFF]=0x11, mem[0x000]=0x12 … mem[0x005]=0x17 (wrap); `IDLE` after beat 8.
- Burst read, code 1, over the same region → 8 `slave_valid` strobes, 11 cycles apart, returning 0x10..0x17.
- Assert `reset_n`=0 at address bit 9 of a write frame → outputs at reset values immediately; target byte unchanged.
- Pulse `valid_s` during `RD_SHIFT` → the stream continues unaffected and no new frame starts.

Source files
------------

// File: rtl/serial_bus_slave.sv
// -----------------------------------------------------------------------------
// serial_bus_slave
//
// Serial bus responder. It decodes three-line frames from the bus master:
//   - a valid_s start strobe,
//   - an MSB-first 14-bit address on addr_tx, with the slave ID in [13:12]
//     and the local byte address in [11:0],
//   - an MSB-first data byte on data_tx,
//   - an MSB-first 3-bit burst code on burst_mode.
// It then reads or writes a local byte memory in single or burst mode. Read
// bytes go back MSB first on data_rx, announced by a one-cycle slave_valid
// strobe. Burst writes are paced beat by beat through slave_ready.
//
// Parameters
//   SLAVE_ID   : compared against frame address bits [13:12]
//   MEM_DEPTH  : local byte memory depth (12-bit local pointer)
//
// Ports
//   clock          in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset (memory is not cleared)
//   valid_s        in   frame / burst-beat start strobe
//   write_en_slave in   1 = write, 0 = read, sampled with valid_s
//   addr_tx        in   serial address, MSB first
//   data_tx        in   serial write data, MSB first
//   burst_mode     in   serial 3-bit burst code, MSB first
//   data_rx        out  serial read data, MSB first
//   slave_ready    out  idle and able to accept a frame or burst beat
//   slave_valid    out  one-cycle strobe; read byte starts on the next cycle
//   rd_data        out  last byte read (debug)
//   state          out  current FSM state (debug)
// -----------------------------------------------------------------------------
module serial_bus_slave #(
  parameter logic [1:0] SLAVE_ID  = 2'd0,
  parameter int         MEM_DEPTH = 4096
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       valid_s,
  input  logic       write_en_slave,
  input  logic       addr_tx,
  input  logic       data_tx,
  input  logic       burst_mode,
  output logic       data_rx,
  output logic       slave_ready,
  output logic       slave_valid,
  output logic [7:0] rd_data,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_COMMIT   = 4'd2,
    ST_RD_FETCH = 4'd3,
    ST_RD_VALID = 4'd4,
    ST_RD_SHIFT = 4'd5,
    ST_BW_WAIT  = 4'd6,
    ST_BW_DATA  = 4'd7
  } state_t;

  // Number of beats in a burst, the frame byte included.
  function automatic logic [9:0] burst_size(input logic [2:0] code);
    logic [9:0] n;
    if (code == 3'd0) begin
      n = 10'd1;
    end else begin
      n = 10'd8 << (code - 3'd1);
    end
    return n;
  endfunction

  state_t      state_r;
  logic [3:0]  bit_cnt_r;
  logic [9:0]  beat_cnt_r;
  logic [13:0] addr_r;
  logic [7:0]  wdata_r;
  logic [2:0]  code_r;
  logic        wr_r;
  logic [11:0] ptr_r;
  logic [7:0]  rshift_r;

  logic        data_rx_r;
  logic        slave_ready_r;
  logic        slave_valid_r;
  logic [7:0]  rd_data_r;

  logic [7:0]  mem_r [MEM_DEPTH];

  logic        id_match_s;
  logic [9:0]  size_s;
  logic [9:0]  beat_next_s;
  logic [11:0] ptr_inc_s;
  logic        mem_we_s;
  logic [11:0] mem_waddr_s;
  logic [7:0]  mem_wdata_s;

  assign id_match_s  = (addr_r[13:12] == SLAVE_ID);
  assign size_s      = burst_size(code_r);
  assign beat_next_s = beat_cnt_r + 10'd1;
  // The local pointer wraps 4095 -> 0; the ID bits are never touched.
  assign ptr_inc_s   = ptr_r + 12'd1;

  assign data_rx     = data_rx_r;
  assign slave_ready = slave_ready_r;
  assign slave_valid = slave_valid_r;
  assign rd_data     = rd_data_r;
  assign state       = state_r;

  // Memory write port: frame byte on commit, burst bytes on the last data bit.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = ptr_r;
    mem_wdata_s = wdata_r;
    case (state_r)
      ST_COMMIT: begin
        if (wr_r && id_match_s) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = addr_r[11:0];
        end else begin
          mem_we_s    = 1'b0;
        end
      end
      ST_BW_DATA: begin
        if (bit_cnt_r == 4'd7) begin
          // The eighth bit is still on data_tx; merge it in directly.
          mem_we_s    = 1'b1;
          mem_waddr_s = ptr_inc_s;
          mem_wdata_s = {wdata_r[6:0], data_tx};
        end else begin
          mem_we_s    = 1'b0;
        end
      end
      default: begin
        mem_we_s = 1'b0;
      end
    endcase
  end

  // Local byte memory; contents survive reset.
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Frame decoder FSM with registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      bit_cnt_r     <= 4'd0;
      beat_cnt_r    <= 10'd0;
      addr_r        <= 14'd0;
      wdata_r       <= 8'd0;
      code_r        <= 3'd0;
      wr_r          <= 1'b0;
      ptr_r         <= 12'd0;
      rshift_r      <= 8'd0;
      data_rx_r     <= 1'b0;
      slave_ready_r <= 1'b1;
      slave_valid_r <= 1'b0;
      rd_data_r     <= 8'd0;
    end else begin
      // The strobe and the serial line are low unless a state drives them.
      slave_valid_r <= 1'b0;
      data_rx_r     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (valid_s) begin
            wr_r          <= write_en_slave;
            bit_cnt_r     <= 4'd0;
            beat_cnt_r    <= 10'd0;
            addr_r        <= 14'd0;
            wdata_r       <= 8'd0;
            code_r        <= 3'd0;
            slave_ready_r <= 1'b0;
            state_r       <= ST_ADDR;
          end else begin
            slave_ready_r <= 1'b1;
          end
        end

        ST_ADDR: begin
          addr_r <= {addr_r[12:0], addr_tx};
          // The data byte rides on address bit cycles 7..14 (counts 6..13).
          if (bit_cnt_r >= 4'd6) begin
            wdata_r <= {wdata_r[6:0], data_tx};
          end
          // The burst code rides on address bit cycles 12..14 (counts 11..13).
          if (bit_cnt_r >= 4'd11) begin
            code_r <= {code_r[1:0], burst_mode};
          end
          if (bit_cnt_r == 4'd13) begin
            state_r <= ST_COMMIT;
          end
          bit_cnt_r <= bit_cnt_r + 4'd1;
        end

        ST_COMMIT: begin
          ptr_r <= addr_r[11:0];
          if (!id_match_s) begin
            slave_ready_r <= 1'b1;
            state_r       <= ST_IDLE;
          end else if (wr_r) begin
            // Both exits of a write are ready states.
            slave_ready_r <= 1'b1;
            if (code_r == 3'd0) begin
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_BW_WAIT;
            end
          end else begin
            state_r <= ST_RD_FETCH;
          end
        end

        ST_RD_FETCH: begin
          rshift_r      <= mem_r[ptr_r];
          rd_data_r     <= mem_r[ptr_r];
          slave_valid_r <= 1'b1;
          state_r       <= ST_RD_VALID;
        end

        ST_RD_VALID: begin
          data_rx_r <= rshift_r[7];
          rshift_r  <= {rshift_r[6:0], 1'b0};
          bit_cnt_r <= 4'd0;
          state_r   <= ST_RD_SHIFT;
        end

        ST_RD_SHIFT: begin
          // Counts 0..7 put out bits 6..0 and then the trailing zero; count 8
          // is the per-beat decision cycle that makes the 11-cycle period.
          if (bit_cnt_r != 4'd8) begin
            data_rx_r <= rshift_r[7];
            rshift_r  <= {rshift_r[6:0], 1'b0};
            bit_cnt_r <= bit_cnt_r + 4'd1;
          end else if ((beat_next_s == size_s) || (code_r == 3'd0)) begin
            slave_ready_r <= 1'b1;
            state_r       <= ST_IDLE;
          end else begin
            ptr_r      <= ptr_inc_s;
            beat_cnt_r <= beat_next_s;
            state_r    <= ST_RD_FETCH;
          end
        end

        ST_BW_WAIT: begin
          if (valid_s) begin
            bit_cnt_r     <= 4'd0;
            slave_ready_r <= 1'b0;
            state_r       <= ST_BW_DATA;
          end else begin
            slave_ready_r <= 1'b1;
          end
        end

        ST_BW_DATA: begin
          wdata_r   <= {wdata_r[6:0], data_tx};
          bit_cnt_r <= bit_cnt_r + 4'd1;
          if (bit_cnt_r == 4'd7) begin
            // The byte itself is written by the memory port this same edge.
            ptr_r         <= ptr_inc_s;
            beat_cnt_r    <= beat_next_s;
            slave_ready_r <= 1'b1;
            if (beat_next_s == (size_s - 10'd1)) begin
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_BW_WAIT;
            end
          end
        end

        default: begin
          slave_ready_r <= 1'b1;
          state_r       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bus_slave.sv
// -----------------------------------------------------------------------------
// tb_serial_bus_slave
//
// Self-checking bench for serial_bus_slave. It plays directed and randomized
// frames and keeps a byte-array model of the slave memory. It predicts the
// read waveform cycle by cycle from the frame timing rules: the strobe in
// cycle 17 + 11*beat, then eight MSB-first bits, otherwise zero.
// -----------------------------------------------------------------------------
module tb_serial_bus_slave;

  localparam logic [1:0] SID     = 2'd0;
  localparam logic [3:0] ST_IDLE = 4'd0;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       valid_s;
  logic       write_en_slave;
  logic       addr_tx;
  logic       data_tx;
  logic       burst_mode;
  logic       data_rx;
  logic       slave_ready;
  logic       slave_valid;
  logic [7:0] rd_data;
  logic [3:0] state;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem_m     [4096];
  bit         written_m [4096];

  serial_bus_slave #(.SLAVE_ID(SID), .MEM_DEPTH(4096)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .valid_s        (valid_s),
    .write_en_slave (write_en_slave),
    .addr_tx        (addr_tx),
    .data_tx        (data_tx),
    .burst_mode     (burst_mode),
    .data_rx        (data_rx),
    .slave_ready    (slave_ready),
    .slave_valid    (slave_valid),
    .rd_data        (rd_data),
    .state          (state)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int burst_len(input logic [2:0] code);
    return (code == 3'd0) ? 1 : (8 << (code - 3'd1));
  endfunction

  function automatic bit all_written(input logic [11:0] a, input logic [2:0] code);
    for (int k = 0; k < burst_len(code); k++) begin
      if (!written_m[12'(a + 12'(k))]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Drives one frame. The call returns in cycle 15 (commit).
  // abort_bit > 0 pulls reset low in that address bit cycle and returns there.
  task automatic send_frame(input bit wr, input logic [13:0] addr, input logic [7:0] data,
                            input logic [2:0] code, input int abort_bit);
    @(negedge clock);
    valid_s        = 1'b1;
    write_en_slave = wr;
    addr_tx        = 1'($urandom);
    data_tx        = 1'($urandom);
    burst_mode     = 1'($urandom);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clock);
      if (k == abort_bit) begin
        reset_n = 1'b0;
        valid_s = 1'b0;
        return;
      end
      // Stray strobes and write-enable noise mid-frame must be ignored.
      valid_s        = ($urandom_range(0, 3) == 0);
      write_en_slave = 1'($urandom);
      addr_tx        = addr[14 - k];
      if (k >= 7) data_tx = data[14 - k];
      else        data_tx = 1'($urandom);
      if (k >= 12) burst_mode = code[14 - k];
      else         burst_mode = 1'($urandom);
    end
    @(negedge clock);
    // Commit cycle: a strobe here must not open a frame on IDLE re-entry.
    valid_s        = 1'($urandom);
    write_en_slave = 1'($urandom);
    addr_tx        = 1'($urandom);
    data_tx        = 1'($urandom);
    burst_mode     = 1'($urandom);
  endtask

  // One burst-write beat: strobe, then 8 data bits, then one settle cycle.
  task automatic bw_beat(input logic [7:0] b, input bit last);
    @(negedge clock);
    check_eq("bw_ready_before", slave_ready, 1'b1);
    valid_s = 1'b1;
    data_tx = 1'($urandom);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      if (i == 1) check_eq("bw_ready_busy", slave_ready, 1'b0);
      valid_s = ($urandom_range(0, 3) == 0);
      data_tx = b[8 - i];
    end
    @(negedge clock);
    valid_s = 1'b0;
    check_eq("bw_ready_after", slave_ready, 1'b1);
    if (last) check_eq("bw_idle_after_last", state, ST_IDLE);
  endtask

  // base >= 0 gives bytes base, base+1, ...; otherwise random bytes.
  task automatic do_write(input logic [1:0] id, input logic [11:0] a, input logic [2:0] code,
                          input int base);
    bit         match = (id == SID);
    int         n     = burst_len(code);
    logic [7:0] b;
    b = (base >= 0) ? 8'(base) : 8'($urandom);
    send_frame(1'b1, {id, a}, b, code, 0);
    @(negedge clock);
    valid_s = 1'b0;
    check_eq("wr_ready_c16", slave_ready, 1'b1);
    check_eq("wr_valid_c16", slave_valid, 1'b0);
    if (!match || code == 3'd0) check_eq("wr_idle_c16", state, ST_IDLE);
    if (match) begin
      mem_m[a]     = b;
      written_m[a] = 1'b1;
      if (code != 3'd0) begin
        for (int k = 1; k < n; k++) begin
          logic [11:0] ak = 12'(a + 12'(k));
          b = (base >= 0) ? 8'(base + k) : 8'($urandom);
          bw_beat(b, k == n - 1);
          mem_m[ak]     = b;
          written_m[ak] = 1'b1;
        end
      end
    end
  endtask

  // pulse_cyc: cycle (relative to the frame strobe) carrying a stray valid_s.
  task automatic do_read(input logic [1:0] id, input logic [11:0] a, input logic [2:0] code,
                         input int pulse_cyc);
    bit match = (id == SID);
    int n     = burst_len(code);
    int last;
    send_frame(1'b0, {id, a}, 8'($urandom), code, 0);
    if (!match) begin
      for (int c = 16; c <= 19; c++) begin
        @(negedge clock);
        valid_s = 1'b0;
        check_eq("rd_nomatch_valid", slave_valid, 1'b0);
        check_eq("rd_nomatch_data", data_rx, 1'b0);
        check_eq("rd_nomatch_ready", slave_ready, 1'b1);
        if (c == 16) check_eq("rd_nomatch_idle", state, ST_IDLE);
      end
      return;
    end
    last = 16 + 11 * n;
    for (int c = 16; c <= last; c++) begin
      int         rel;
      int         off;
      logic [7:0] bt;
      logic       exp_v;
      logic       exp_d;
      @(negedge clock);
      valid_s        = (c == pulse_cyc);
      write_en_slave = (c == pulse_cyc) ? 1'b1 : 1'($urandom);
      rel   = c - 17;
      off   = (rel >= 0) ? (rel % 11) : 0;
      bt    = (rel >= 0) ? mem_m[12'(a + 12'(rel / 11))] : 8'd0;
      exp_v = (rel >= 0) && (off == 0);
      exp_d = ((rel >= 0) && (off >= 1) && (off <= 8)) ? bt[8 - off] : 1'b0;
      check_eq("rd_valid", slave_valid, exp_v);
      check_eq("rd_data_rx", data_rx, exp_d);
      check_eq("rd_ready", slave_ready, (c == last));
      if (exp_v) check_eq("rd_byte", rd_data, bt);
      if (c == last) check_eq("rd_idle_end", state, ST_IDLE);
    end
    valid_s = 1'b0;
  endtask

  task automatic run_random();
    logic [1:0]  id;
    logic [11:0] a;
    logic [2:0]  code;
    logic [2:0]  code2;
    for (int it = 0; it < 12; it++) begin
      id   = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : SID;
      a    = 12'($urandom_range(0, 31)) + (($urandom_range(0, 1) == 1) ? 12'hFF0 : 12'h300);
      code = 3'($urandom_range(0, 2));
      do_write(id, a, code, -1);
      do_read(id, a, code, 18 + $urandom_range(0, 8));
      code2 = 3'($urandom_range(0, 2));
      if (!all_written(a, code2)) code2 = 3'd0;
      if (written_m[a]) do_read(SID, a, code2, -1);
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    valid_s        = 1'b0;
    write_en_slave = 1'b0;
    addr_tx        = 1'b0;
    data_tx        = 1'b0;
    burst_mode     = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("rst_data_rx", data_rx, 1'b0);
    check_eq("rst_valid", slave_valid, 1'b0);
    check_eq("rst_ready", slave_ready, 1'b1);
    check_eq("rst_rd_data", rd_data, 8'h00);
    check_eq("rst_state", state, ST_IDLE);
    reset_n = 1'b1;
    @(negedge clock);
    check_eq("post_rst_ready", slave_ready, 1'b1);

    // Single write and read-back.
    do_write(SID, 12'h123, 3'd0, 8'hA5);
    do_read(SID, 12'h123, 3'd0, -1);
    check_eq("a5_rd_data", rd_data, 8'hA5);

    // Foreign ID (address 0x1123) leaves local 0x123 alone.
    do_write(2'd1, 12'h123, 3'd0, 8'h5A);
    do_read(SID, 12'h123, 3'd0, -1);
    do_read(2'd1, 12'h123, 3'd0, -1);

    // Burst write across the 4095 -> 0 wrap, then burst read it back.
    do_write(SID, 12'hFFE, 3'd1, 8'h10);
    check_eq("wrap_mem_000", mem_m[12'h000], 8'h12);
    do_read(SID, 12'hFFE, 3'd1, -1);

    // Stray valid_s inside the read stream.
    do_read(SID, 12'hFFE, 3'd0, 21);
    do_read(SID, 12'hFFE, 3'd1, 40);

    // Reset during address bit 9 of a write frame.
    do_write(SID, 12'h200, 3'd0, 8'h33);
    send_frame(1'b1, {SID, 12'h200}, 8'h77, 3'd0, 9);
    #1;
    check_eq("abort_data_rx", data_rx, 1'b0);
    check_eq("abort_valid", slave_valid, 1'b0);
    check_eq("abort_ready", slave_ready, 1'b1);
    check_eq("abort_rd_data", rd_data, 8'h00);
    check_eq("abort_state", state, ST_IDLE);
    @(negedge clock);
    reset_n = 1'b1;
    do_read(SID, 12'h200, 3'd0, -1);
    check_eq("abort_byte_kept", rd_data, 8'h33);

    run_random();

    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
